ndp_stream_scheduler: RTL

Command-driven sequencer between the PS DMA AXI4-Stream pair and the NDP_core systolic-array bank. It parses a header word at the start of each input packet. It then routes the payload either as weights to one selected systolic array or as activations broadcast to the bank. For compute commands it forwards the returning results to the output stream with a correctly placed tlast. Packet-length mismatches are detected and recovered from without deadlocking the DMA.

---
 rtl/ndp_stream_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ndp_stream_scheduler.sv
// rtl/ndp_stream_scheduler.sv - header-driven router between the DMA streams and the systolic-array bank
module ndp_stream_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int SYS_WIDTH  = 16,
  parameter int LEN_BITS   = 16,
  localparam int SEL_BITS  = $clog2(SYS_WIDTH)
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  output logic [SEL_BITS-1:0]   w_sel,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_valid,
  input  logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  r_valid,
  output logic                  r_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {S_HDR, S_LOAD, S_FEED, S_DRAIN, S_FLUSH} state_t;

  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] len_q, fed_q, out_q, fed_nx;
  logic [SEL_BITS-1:0] sel_q;
  logic                flush_pend_q, feed_done_q, err_q;

  logic [3:0]          hdr_op, hdr_sel;
  logic [LEN_BITS-1:0] hdr_len;
  logic                hdr_load_ok, hdr_comp_ok;
  logic                s_fire, m_fire, at_len, beat_last, early_last, missing_last;
  logic                res_ok, res_last;

  assign hdr_op      = s_axis_tdata[31:28];
  assign hdr_sel     = s_axis_tdata[27:24];
  assign hdr_len     = s_axis_tdata[LEN_BITS-1:0];
  assign hdr_load_ok = (hdr_op == 4'd1) && ({28'd0, hdr_sel} < 32'(SYS_WIDTH)) && (hdr_len != '0);
  assign hdr_comp_ok = (hdr_op == 4'd2) && (hdr_len != '0);

  // Length check: a beat ends the command on reaching N or on tlast, whichever comes first.
  assign fed_nx       = fed_q + 1'b1;
  assign at_len       = (fed_nx == len_q);
  assign beat_last    = at_len | s_axis_tlast;
  assign early_last   = s_axis_tlast & ~at_len;
  assign missing_last = at_len & ~s_axis_tlast;

  assign res_ok   = (out_q < fed_q);
  assign res_last = feed_done_q & ((out_q + 1'b1) == fed_q);

  assign s_fire = s_axis_tvalid & s_axis_tready;
  assign m_fire = m_axis_tvalid & m_axis_tready;

  assign w_data       = s_axis_tdata;
  assign a_data       = s_axis_tdata;
  assign m_axis_tdata = r_data;
  assign w_sel        = sel_q;
  assign busy         = (state_q != S_HDR);
  assign err          = err_q;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) state_q <= S_HDR;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR: begin
        if (s_fire) begin
          if (hdr_load_ok)       state_d = S_LOAD;
          else if (hdr_comp_ok)  state_d = S_FEED;
          else if (!s_axis_tlast) state_d = S_FLUSH;
        end
      end
      S_LOAD:  if (s_fire && beat_last) state_d = (flush_pend_q || missing_last) ? S_FLUSH : S_HDR;
      S_FEED:  if (s_fire && beat_last) state_d = S_DRAIN;
      S_DRAIN: if (m_fire && m_axis_tlast) state_d = flush_pend_q ? S_FLUSH : S_HDR;
      S_FLUSH: if (s_fire && s_axis_tlast) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  // Reset gates every handshake so nothing moves while the block is held.
  always_comb begin
    s_axis_tready = 1'b0;
    w_valid       = 1'b0;
    a_valid       = 1'b0;
    r_ready       = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (!axi_areset) begin
      case (state_q)
        S_HDR:   s_axis_tready = 1'b1;
        S_LOAD: begin
          w_valid       = s_axis_tvalid;
          s_axis_tready = w_ready;
        end
        S_FEED: begin
          a_valid       = s_axis_tvalid;
          s_axis_tready = a_ready;
          m_axis_tvalid = r_valid & res_ok;
          r_ready       = m_axis_tready & res_ok;
          m_axis_tlast  = res_last;
        end
        S_DRAIN: begin
          m_axis_tvalid = r_valid & res_ok;
          r_ready       = m_axis_tready & res_ok;
          m_axis_tlast  = res_last;
        end
        S_FLUSH: s_axis_tready = 1'b1;
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      len_q        <= '0;
      fed_q        <= '0;
      out_q        <= '0;
      sel_q        <= '0;
      flush_pend_q <= 1'b0;
      feed_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_HDR: begin
          if (s_fire) begin
            sel_q        <= SEL_BITS'(hdr_sel);
            len_q        <= hdr_len;
            fed_q        <= '0;
            out_q        <= '0;
            feed_done_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            if (!hdr_load_ok && !hdr_comp_ok) err_q <= 1'b1;
          end
        end
        S_LOAD, S_FEED: begin
          if (s_fire) begin
            fed_q <= fed_nx;
            if (early_last || missing_last) err_q <= 1'b1;
            if (missing_last) flush_pend_q <= 1'b1;
            if (state_q == S_FEED && beat_last) feed_done_q <= 1'b1;
          end
        end
        S_FLUSH: if (s_fire && s_axis_tlast) flush_pend_q <= 1'b0;
        default: ;
      endcase
      if (m_fire) out_q <= out_q + 1'b1;
    end
  end

endmodule
